// File: rtl/onedconv_row_sequencer.sv
// Row sequencer for the 1D-convolution engine: fetches each image row from pixel memory,
// streams it to the datapath and paces engine reset/enable/start. Optional macro: ONEDCONV_ROWSEQ_STALL_EN.
module onedconv_row_sequencer #(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  ONEDCONV_ROWSEQ_Clk,
  input  logic                  ONEDCONV_ROWSEQ_Reset,
  input  logic                  ONEDCONV_ROWSEQ_Go,
  input  logic [ADDR_WIDTH-1:0] ONEDCONV_ROWSEQ_Base_Addr,
  output logic                  ONEDCONV_ROWSEQ_Busy,
  output logic                  ONEDCONV_ROWSEQ_Done,
  output logic [7:0]            ONEDCONV_ROWSEQ_Row_Index,
  output logic                  ONEDCONV_ROWSEQ_Mem_Rd,
  output logic [ADDR_WIDTH-1:0] ONEDCONV_ROWSEQ_Mem_Addr,
  input  logic [DATA_WIDTH-1:0] ONEDCONV_ROWSEQ_Mem_Data,
  output logic [DATA_WIDTH-1:0] ONEDCONV_ROWSEQ_Pix_Data,
  output logic                  ONEDCONV_ROWSEQ_Pix_Valid,
  input  logic                  ONEDCONV_ROWSEQ_Stall,
  output logic                  ONEDCONV_ROWSEQ_Conv_En,
  output logic                  ONEDCONV_ROWSEQ_Conv_Start,
  output logic                  ONEDCONV_ROWSEQ_Conv_Reset_n,
  input  logic                  ONEDCONV_ROWSEQ_Conv_Out_Valid,
  output logic [2:0]            ONEDCONV_ROWSEQ_Dbg_State
);

  localparam logic [7:0] W8   = 8'(IMG_WIDTH);
  localparam logic [7:0] OPR8 = 8'(IMG_WIDTH - KERNEL_SIZE + 1);
  localparam logic [7:0] LAST_ROW = 8'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_CLR, S_ROW_EN, S_ROW_START, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            row_q, row_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;
  logic [7:0]            out_cnt_q, out_cnt_d;
  logic                  pend_q;
  logic                  stall_eff;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic                  rd_issue, pix_emit, cnt_hit, cnt_full;

`ifdef ONEDCONV_ROWSEQ_STALL_EN
  logic [DATA_WIDTH-1:0] skid_data_d;

  assign stall_eff = ONEDCONV_ROWSEQ_Stall;

  // A return that lands while stalled parks here; it leaves on the first free cycle.
  always_comb begin
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (stall_eff && pend_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = ONEDCONV_ROWSEQ_Mem_Data;
    end else if (!stall_eff) begin
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge ONEDCONV_ROWSEQ_Clk) begin
    if (ONEDCONV_ROWSEQ_Reset) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign stall_eff   = ONEDCONV_ROWSEQ_Stall & 1'b0;
  assign skid_v_q    = 1'b0;
  assign skid_v_d    = 1'b0;
  assign skid_data_q = '0;
`endif

  assign rd_issue = (state_q == S_STREAM) && !stall_eff && !skid_v_q;
  assign pix_emit = !stall_eff && (skid_v_q || pend_q);
  assign cnt_hit  = (state_q inside {S_ROW_START, S_STREAM, S_DRAIN}) &&
                    ONEDCONV_ROWSEQ_Conv_Out_Valid && (out_cnt_q < OPR8);
  // The pulse arriving this cycle counts, so DRAIN can leave on the edge that ends it.
  assign cnt_full = (out_cnt_q == OPR8) || (cnt_hit && (out_cnt_q == OPR8 - 8'd1));

  always_ff @(posedge ONEDCONV_ROWSEQ_Clk) begin
    if (ONEDCONV_ROWSEQ_Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      row_q     <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      pend_q    <= rd_issue;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    row_d     = row_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = cnt_hit ? out_cnt_q + 8'd1 : out_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ONEDCONV_ROWSEQ_Go) begin
          addr_d  = ONEDCONV_ROWSEQ_Base_Addr;
          row_d   = '0;
          state_d = S_ROW_CLR;
        end
      end
      S_ROW_CLR: begin
        out_cnt_d = '0;
        rd_cnt_d  = '0;
        state_d   = S_ROW_EN;
      end
      S_ROW_EN:    state_d = S_ROW_START;
      S_ROW_START: state_d = S_STREAM;
      S_STREAM: begin
        if (rd_issue) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          rd_cnt_d = rd_cnt_q + 8'd1;
          if (rd_cnt_q == W8 - 8'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_full && !skid_v_d) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 8'd1;
            state_d = S_ROW_CLR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ONEDCONV_ROWSEQ_Busy         = (state_q != S_IDLE);
    ONEDCONV_ROWSEQ_Done         = (state_q == S_DONE);
    ONEDCONV_ROWSEQ_Row_Index    = (state_q == S_IDLE) ? 8'd0 : row_q;
    ONEDCONV_ROWSEQ_Mem_Rd       = rd_issue;
    ONEDCONV_ROWSEQ_Mem_Addr     = rd_issue ? addr_q : '0;
    ONEDCONV_ROWSEQ_Pix_Valid    = pix_emit;
    ONEDCONV_ROWSEQ_Pix_Data     = !pix_emit ? '0 :
                                   (skid_v_q ? skid_data_q : ONEDCONV_ROWSEQ_Mem_Data);
    ONEDCONV_ROWSEQ_Conv_En      = (state_q inside {S_ROW_EN, S_ROW_START, S_STREAM, S_DRAIN});
    ONEDCONV_ROWSEQ_Conv_Reset_n = (state_q inside {S_ROW_EN, S_ROW_START, S_STREAM, S_DRAIN});
    ONEDCONV_ROWSEQ_Conv_Start   = (state_q == S_ROW_START);
    ONEDCONV_ROWSEQ_Dbg_State    = state_q;
  end

endmodule

// File: tb/tb_onedconv_row_sequencer.sv
// Bench for onedconv_row_sequencer: directed frames compared cycle by cycle against a
// queue-based frame model built from the per-cycle stall and result-pulse tables.
module tb_onedconv_row_sequencer;
  localparam int W = 5, H = 2, K = 3, DW = 8, AW = 10, OPR = W - K + 1, NCYC = 40;
  localparam logic [AW-1:0] BASE = 10'h010;
`ifdef ONEDCONV_ROWSEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, go, stall, ov;
  logic [AW-1:0] base;
  logic [DW-1:0] mem_data;
  logic busy, done, mem_rd, pix_valid, conv_en, conv_start, conv_rstn;
  logic [7:0] row_idx;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] pix_data;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  onedconv_row_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .ONEDCONV_ROWSEQ_Clk(clk),
    .ONEDCONV_ROWSEQ_Reset(rst),
    .ONEDCONV_ROWSEQ_Go(go),
    .ONEDCONV_ROWSEQ_Base_Addr(base),
    .ONEDCONV_ROWSEQ_Busy(busy),
    .ONEDCONV_ROWSEQ_Done(done),
    .ONEDCONV_ROWSEQ_Row_Index(row_idx),
    .ONEDCONV_ROWSEQ_Mem_Rd(mem_rd),
    .ONEDCONV_ROWSEQ_Mem_Addr(mem_addr),
    .ONEDCONV_ROWSEQ_Mem_Data(mem_data),
    .ONEDCONV_ROWSEQ_Pix_Data(pix_data),
    .ONEDCONV_ROWSEQ_Pix_Valid(pix_valid),
    .ONEDCONV_ROWSEQ_Stall(stall),
    .ONEDCONV_ROWSEQ_Conv_En(conv_en),
    .ONEDCONV_ROWSEQ_Conv_Start(conv_start),
    .ONEDCONV_ROWSEQ_Conv_Reset_n(conv_rstn),
    .ONEDCONV_ROWSEQ_Conv_Out_Valid(ov),
    .ONEDCONV_ROWSEQ_Dbg_State(dbg_state)
  );

  int n_checks = 0, n_errors = 0;
  bit st_tab[NCYC];
  bit ov_tab[NCYC];
  logic exp_busy[NCYC], exp_done[NCYC], exp_rd[NCYC], exp_pv[NCYC];
  logic exp_en[NCYC], exp_start[NCYC], exp_rstn[NCYC];
  logic [AW-1:0] exp_addr[NCYC];
  logic [DW-1:0] exp_pd[NCYC];
  logic [7:0] exp_row[NCYC];
  bit chk_on = 1'b0;
  int cyc = 0;
  string scen = "init";

  function automatic logic [DW-1:0] pix_of(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s cyc=%0d actual=%0h required=%0h", scen, name, cyc, act, exp);
    end
  endtask

  task automatic set_ctl(input int c, input bit b, input bit e, input bit s, input bit rn,
                         input bit d, input int r);
    exp_busy[c] = b; exp_en[c] = e; exp_start[c] = s; exp_rstn[c] = rn;
    exp_done[c] = d; exp_row[c] = 8'(r);
  endtask

  task automatic set_idle(input int c);
    set_ctl(c, 0, 0, 0, 0, 0, 0);
    exp_rd[c] = 1'b0; exp_pv[c] = 1'b0; exp_addr[c] = '0; exp_pd[c] = '0;
  endtask

  // Frame model: row phases are fixed-length, pixels flow through a FIFO of returned
  // data, a row ends once every pixel is out and OPR result pulses have been seen.
  task automatic build_model(input int rst_cyc);
    int s, c, nread, cnt;
    bit hold, st, inflight, drain;
    logic [AW-1:0] addr, in_addr;
    logic [DW-1:0] q[$];
    for (int i = 0; i < NCYC; i++) set_idle(i);
    s = 1; addr = BASE; c = 0; in_addr = '0;
    for (int r = 0; r < H; r++) begin
      if (s + 2 >= NCYC) break;
      set_ctl(s, 1, 0, 0, 0, 0, r);
      set_ctl(s + 1, 1, 1, 0, 1, 0, r);
      set_ctl(s + 2, 1, 1, 1, 1, 0, r);
      cnt = ov_tab[s + 2] ? 1 : 0;
      nread = 0; inflight = 1'b0; q.delete();
      c = s + 3;
      while (c < NCYC) begin
        set_ctl(c, 1, 1, 0, 1, 0, r);
        st = STALL_EN && st_tab[c];
        drain = (nread == W);
        hold = (q.size() != 0);
        if (inflight) q.push_back(pix_of(in_addr));
        inflight = 1'b0;
        if (!st) begin
          if (q.size() != 0) begin exp_pv[c] = 1'b1; exp_pd[c] = q.pop_front(); end
          if (!hold && !drain) begin
            exp_rd[c] = 1'b1; exp_addr[c] = addr;
            inflight = 1'b1; in_addr = addr; addr = addr + 1'b1; nread++;
          end
        end
        if (ov_tab[c] && cnt < OPR) cnt++;
        if (drain && q.size() == 0 && cnt == OPR) break;
        c++;
      end
      s = c + 1;
    end
    if (s < NCYC) set_ctl(s, 1, 0, 0, 0, 1, H - 1);
    if (rst_cyc >= 0)
      for (int i = rst_cyc + 1; i < NCYC; i++) set_idle(i);
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < NCYC; i++) begin st_tab[i] = 1'b0; ov_tab[i] = 1'b0; end
  endtask

  task automatic nominal_ov();
    ov_tab[7] = 1; ov_tab[8] = 1; ov_tab[9] = 1;
    ov_tab[16] = 1; ov_tab[17] = 1; ov_tab[18] = 1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(exp_busy[cyc]));
      check("done", 32'(done), 32'(exp_done[cyc]));
      check("mem_rd", 32'(mem_rd), 32'(exp_rd[cyc]));
      check("pix_valid", 32'(pix_valid), 32'(exp_pv[cyc]));
      check("conv_en", 32'(conv_en), 32'(exp_en[cyc]));
      check("conv_start", 32'(conv_start), 32'(exp_start[cyc]));
      check("conv_reset_n", 32'(conv_rstn), 32'(exp_rstn[cyc]));
      check("row_index", 32'(row_idx), 32'(exp_row[cyc]));
      if (exp_rd[cyc] || !exp_busy[cyc]) check("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
      if (exp_pv[cyc] || !exp_busy[cyc]) check("pix_data", 32'(pix_data), 32'(exp_pd[cyc]));
    end
  end

  task automatic run_scen(input string name, input int rst_cyc);
    logic prev_rd;
    logic [AW-1:0] prev_addr;
    scen = name;
    build_model(rst_cyc);
    prev_rd = 1'b0; prev_addr = '0;
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      go = (c == 0);
      rst = (c == rst_cyc);
      stall = st_tab[c];
      ov = ov_tab[c];
      mem_data = prev_rd ? pix_of(prev_addr) : '0;
      chk_on = 1'b1;
      @(negedge clk);
      prev_rd = mem_rd; prev_addr = mem_addr;
      @(posedge clk); #1;
    end
    chk_on = 1'b0;
    go = 0; rst = 0; stall = 0; ov = 0; mem_data = '0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b1; stall = 1'b0; ov = 1'b1; base = BASE; mem_data = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    scen = "reset";
    check("busy", 32'(busy), 0);
    check("done", 32'(done), 0);
    check("mem_rd", 32'(mem_rd), 0);
    check("mem_addr", 32'(mem_addr), 0);
    check("pix_valid", 32'(pix_valid), 0);
    check("pix_data", 32'(pix_data), 0);
    check("conv_en", 32'(conv_en), 0);
    check("conv_start", 32'(conv_start), 0);
    check("conv_reset_n", 32'(conv_rstn), 0);
    check("row_index", 32'(row_idx), 0);
    check("dbg_state", 32'(dbg_state), 0);
    @(posedge clk); #1;
    go = 0; ov = 0; mem_data = '0;

    // Hand-derived anchors for the nominal frame and the stall case pin the model.
    scen = "model_nominal";
    clear_tabs(); nominal_ov(); build_model(-1);
    check("start_c3", 32'(exp_start[3]), 1);
    check("addr_c4", 32'(exp_rd[4] ? exp_addr[4] : 10'h3FF), 32'h010);
    check("addr_c8", 32'(exp_rd[8] ? exp_addr[8] : 10'h3FF), 32'h014);
    check("rd_c9", 32'(exp_rd[9]), 0);
    check("pv_c5", 32'(exp_pv[5]), 1);
    check("pv_c9", 32'(exp_pv[9]), 1);
    check("pv_c10", 32'(exp_pv[10]), 0);
    check("rstn_c10", 32'(exp_rstn[10]), 0);
    check("addr_c13", 32'(exp_rd[13] ? exp_addr[13] : 10'h3FF), 32'h015);
    check("row_c13", 32'(exp_row[13]), 1);
    check("done_c19", 32'(exp_done[19]), 1);
    check("busy_c20", 32'(exp_busy[20]), 0);

    clear_tabs(); nominal_ov();
    run_scen("nominal", -1);

`ifdef ONEDCONV_ROWSEQ_STALL_EN
    clear_tabs();
    st_tab[6] = 1; st_tab[7] = 1;
    ov_tab[7] = 1; ov_tab[8] = 1; ov_tab[9] = 1;
    ov_tab[19] = 1; ov_tab[20] = 1; ov_tab[21] = 1;
    scen = "model_stall";
    build_model(-1);
    check("rd_c6", 32'(exp_rd[6]), 0);
    check("rd_c8", 32'(exp_rd[8]), 0);
    check("pd_c8", 32'(exp_pv[8] ? exp_pd[8] : 8'h00), 32'(8'h11 ^ 8'h5A));
    check("addr_c9", 32'(exp_rd[9] ? exp_addr[9] : 10'h3FF), 32'h012);
    run_scen("stall", -1);
`else
    clear_tabs(); nominal_ov();
    for (int i = 0; i < NCYC; i++) st_tab[i] = 1'($urandom_range(0, 1));
    run_scen("stall_ignored", -1);
`endif

    clear_tabs();
    ov_tab[2] = 1; ov_tab[3] = 1; ov_tab[6] = 1; ov_tab[19] = 1;
    ov_tab[22] = 1; ov_tab[23] = 1; ov_tab[24] = 1; ov_tab[25] = 1;
    scen = "model_drain";
    build_model(-1);
    check("rstn_c19", 32'(exp_rstn[19]), 1);
    check("rstn_c20", 32'(exp_rstn[20]), 0);
    run_scen("drain_wait", -1);

    clear_tabs(); nominal_ov();
    run_scen("reset_mid", 6);
    clear_tabs(); nominal_ov();
    run_scen("restart", -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/onedconv_row_sequencer.md
# onedconv_row_sequencer

Initiator side of the 1D-convolution row handshake. It fetches image rows from pixel memory, streams them to the 1D-convolution datapath, and drives that engine's enable, start and active-low reset. It counts result samples per row and advances row by row until a frame is done. It sits between the frame-level controller (Go/Done) and the convolution engine plus its pixel memory.

## Interface
- IMG_WIDTH, 28: pixels per row; must be at most 255.
- IMG_HEIGHT, 28: rows per frame; must be at most 256.
- KERNEL_SIZE, 3: taps; valid outputs per row are OUT_PER_ROW = IMG_WIDTH-KERNEL_SIZE+1.
- DATA_WIDTH, 8: pixel width.
- ADDR_WIDTH, 10: pixel memory address width.

Ports (name, direction, width, meaning):
- ONEDCONV_ROWSEQ_Clk, in, 1: single clock; all logic on rising edge.
- ONEDCONV_ROWSEQ_Reset, in, 1: synchronous, active-high reset.
- ONEDCONV_ROWSEQ_Go, in, 1: frame start request; sampled only in IDLE.
- ONEDCONV_ROWSEQ_Base_Addr, in, ADDR_WIDTH: frame base address; captured on accepted Go.
- ONEDCONV_ROWSEQ_Busy, out, 1: high from ROW_CLR through DONE inclusive.
- ONEDCONV_ROWSEQ_Done, out, 1: one-cycle pulse at end of frame.
- ONEDCONV_ROWSEQ_Row_Index, out, 8: current row number, starting at 0.
- ONEDCONV_ROWSEQ_Mem_Rd, out, 1: memory read strobe.
- ONEDCONV_ROWSEQ_Mem_Addr, out, ADDR_WIDTH: read address.
- ONEDCONV_ROWSEQ_Mem_Data, in, DATA_WIDTH: read data, valid exactly 1 cycle after Mem_Rd.
- ONEDCONV_ROWSEQ_Pix_Data, out, DATA_WIDTH: pixel to the convolution datapath.
- ONEDCONV_ROWSEQ_Pix_Valid, out, 1: Pix_Data qualifier.
- ONEDCONV_ROWSEQ_Stall, in, 1: downstream backpressure.
- ONEDCONV_ROWSEQ_Conv_En, out, 1: engine enable.
- ONEDCONV_ROWSEQ_Conv_Start, out, 1: engine start pulse.
- ONEDCONV_ROWSEQ_Conv_Reset_n, out, 1: engine reset, active-low.
- ONEDCONV_ROWSEQ_Conv_Out_Valid, in, 1: one pulse per engine result sample.

## Operation
- **States:**
  - IDLE -> ROW_CLR -> ROW_EN -> ROW_START -> STREAM -> DRAIN.
  - From DRAIN: go to ROW_CLR for the next row, or to DONE if this was the last row.
  - DONE -> IDLE.
- **IDLE**
  - Conv_Reset_n=0; all other outputs 0.
  - If Go=1: capture Base_Addr, clear the row counter, go to ROW_CLR.
- **ROW_CLR** (1 cycle): Conv_Reset_n=0 to return the engine to its reset state.
- **ROW_EN** (1 cycle): Conv_Reset_n=1, Conv_En=1. Conv_En then stays 1 through DRAIN.
- **ROW_START** (1 cycle): Conv_Start=1.
- **STREAM**
  - Issues IMG_WIDTH reads at consecutive addresses, one per non-stalled cycle.
  - The running address register starts at Base_Addr for row 0 and continues linearly across rows, so row r begins at Base + r·IMG_WIDTH.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
  - Leaves for DRAIN after the last read is issued.
- **Pixel path:** returned Mem_Data goes to Pix_Data with Pix_Valid=1 in the return cycle, unless stalled.
- **DRAIN:** waits until every issued pixel has been emitted and the output counter equals OUT_PER_ROW.
- **Output counter**
  - Counts Conv_Out_Valid pulses in ROW_START, STREAM and DRAIN; cleared in ROW_CLR.
  - Pulses beyond OUT_PER_ROW are ignored.
  - Pulses in IDLE, ROW_CLR, ROW_EN and DONE are ignored.
- **Row advance:** when Row_Index = IMG_HEIGHT-1, DRAIN goes to DONE; otherwise increment Row_Index and go to ROW_CLR.
- **DONE:** Done=1 and Busy=1 for one cycle, then IDLE.
- **Go handling:** Go outside IDLE is ignored. Go and Reset in the same cycle: Reset wins.
- **Reset mid-operation:** at the next edge, state becomes IDLE, all counters clear, and outputs take their reset values. Any in-flight memory return is discarded.

## Timing
- **Reset values:** Conv_Reset_n=0; Busy, Done, Mem_Rd, Pix_Valid, Conv_En, Conv_Start = 0; Mem_Addr, Pix_Data, Row_Index = 0.
- **First row, with Go sampled at edge 0:**
  - ROW_CLR in cycle 1, ROW_EN in cycle 2, Conv_Start in cycle 3.
  - First Mem_Rd in cycle 4; first Pix_Valid in cycle 5.
- **Unstalled row:** Mem_Rd in cycles 4..IMG_WIDTH+3; Pix_Valid in cycles 5..IMG_WIDTH+4.
- **Row-to-row overhead:** 3 cycles (ROW_CLR, ROW_EN, ROW_START) after DRAIN exits.
- **Stall**
  - While Stall=1: Mem_Rd=0 and Pix_Valid=0.
  - Data returning during a stall (read issued the cycle before) is held in a 1-entry skid register.
  - On the first cycle with Stall=0, the skid entry is emitted first and no new read is issued that cycle; reads resume the following cycle.
  - Pixel order is preserved and no pixel is lost or duplicated.
  - Stall has no effect on the control pulses.

## Configuration
- **ONEDCONV_ROWSEQ_STALL_EN defined:** Stall and the skid register are implemented as in Timing.
- **Macro undefined:**
  - The Stall port exists but is ignored and the skid register is removed.
  - Reads issue every STREAM cycle; Pix_Valid always follows Mem_Rd by exactly 1 cycle.

## Test plan
All scenarios use IMG_WIDTH=5, IMG_HEIGHT=2, KERNEL_SIZE=3, Base_Addr=0x010.

- **Reset values:** Reset held 2 cycles -> every output at its reset value; Conv_Reset_n=0.
- **Nominal frame**
  - Stimulus: Go at edge 0; 3 Conv_Out_Valid pulses per row.
  - Required: Conv_Start in cycle 3; Mem_Addr 0x010..0x014 in cycles 4-8; Pix_Valid in cycles 5-9.
  - Required: row 1 reads 0x015..0x019 with Row_Index=1; Done pulses once; Busy falls the cycle after Done.
- **Stall (macro defined)**
  - Stimulus: Stall=1 in cycles 6-7 of row 0.
  - Required: no Mem_Rd in cycles 6-8; the pixel from 0x011 is emitted in cycle 8; exactly 5 pixels in address order.
- **Drain wait:** withhold the third Conv_Out_Valid for 10 cycles -> sequencer stays in DRAIN; ROW_CLR (Conv_Reset_n=0) follows 1 cycle after that pulse.
- **Reset mid-STREAM:** Reset in cycle 6 -> cycle 7 shows IDLE with Mem_Rd=0 and Conv_Reset_n=0; a new Go restarts at 0x010 with Row_Index=0.
- **Macro undefined:** random Stall toggling -> Pix_Valid timing identical to the nominal frame.
